soml_frame_feeder: RTL and testbench

// Initiator side of the soml_decoder_top input interface. Accepts one frame (H 4x4

---
 rtl/soml_frame_feeder.sv | 158 +++++++++++++++
 tb/tb_soml_frame_feeder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soml_frame_feeder.sv
// Frame feeder for the soml decoder: buffers one H/Y frame from a load stream,
// replays it to the decoder (H row-major) and reports the decoded word or a timeout.
module soml_frame_feeder #(
  parameter int N       = 32,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int Y_LEN   = 8,
  parameter int RES_W   = 12,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [N-1:0]     ld_r,
  input  logic [N-1:0]     ld_i,
  output logic             start,
  output logic             H_in_valid,
  output logic [N-1:0]     H_in_r,
  output logic [N-1:0]     H_in_i,
  output logic             Y_in_valid,
  output logic [N-1:0]     Y_in_r,
  output logic [N-1:0]     Y_in_i,
  input  logic             output_valid,
  input  logic [RES_W-1:0] signal_in,
  output logic             res_valid,
  output logic [RES_W-1:0] res_bits,
  output logic             res_timeout,
  output logic             busy
);

  localparam int H_LEN = ROWS * COLS;
  localparam int TOT   = H_LEN + Y_LEN;
  localparam int IW    = (TOT > 1) ? $clog2(TOT) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TW    = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_GAP, S_DRIVE, S_WAIT, S_DONE
  } state_t;

  state_t state, state_nxt;

  // Load order is kept as-is; H is column-major there, so DRIVE transposes on read.
  logic [N-1:0]  buf_r [TOT];
  logic [N-1:0]  buf_i [TOT];

  logic [IW-1:0] ld_cnt;
  logic [RW-1:0] drv_r;
  logic [CW-1:0] drv_c;
  logic [TW-1:0] wait_cnt;
  int            drv_j;
  logic [IW-1:0] h_idx;
  logic [IW-1:0] y_idx;
  logic          accept;
  logic          last_ld;
  logic          last_drv;
  logic          got_result;
  logic          expired;

  assign accept     = ld_ready & ld_valid;
  assign last_ld    = (ld_cnt == IW'(TOT - 1));
  assign last_drv   = (drv_r == RW'(ROWS - 1)) && (drv_c == CW'(COLS - 1));
  assign drv_j      = int'(drv_r) * COLS + int'(drv_c);
  assign h_idx      = IW'(int'(drv_c) * ROWS + int'(drv_r));
  assign y_idx      = IW'(H_LEN + drv_j);
  // A result arriving on the expiring cycle wins over the timeout.
  assign got_result = (state == S_WAIT) && output_valid;
  assign expired    = (state == S_WAIT) && !output_valid && (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    start      = 1'b0;
    busy       = 1'b1;
    H_in_valid = 1'b0;
    H_in_r     = '0;
    H_in_i     = '0;
    Y_in_valid = 1'b0;
    Y_in_r     = '0;
    Y_in_i     = '0;
    case (state)
      S_IDLE, S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b0;
        if (ld_valid) state_nxt = last_ld ? S_START : S_LOAD;
      end
      S_START: begin
        start     = 1'b1;
        state_nxt = S_GAP;
      end
      S_GAP: state_nxt = S_DRIVE;
      S_DRIVE: begin
        H_in_valid = 1'b1;
        H_in_r     = buf_r[h_idx];
        H_in_i     = buf_i[h_idx];
        if (drv_j < Y_LEN) begin
          Y_in_valid = 1'b1;
          Y_in_r     = buf_r[y_idx];
          Y_in_i     = buf_i[y_idx];
        end
        if (last_drv) state_nxt = S_WAIT;
      end
      S_WAIT: if (got_result || expired) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_r[ld_cnt] <= ld_r;
      buf_i[ld_cnt] <= ld_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt      <= '0;
      drv_r       <= '0;
      drv_c       <= '0;
      wait_cnt    <= '0;
      res_valid   <= 1'b0;
      res_bits    <= '0;
      res_timeout <= 1'b0;
    end else begin
      res_valid   <= 1'b0;
      res_bits    <= '0;
      res_timeout <= 1'b0;
      if (accept) ld_cnt <= last_ld ? '0 : ld_cnt + 1'b1;
      if (state == S_DRIVE) begin
        if (drv_c == CW'(COLS - 1)) begin
          drv_c <= '0;
          drv_r <= last_drv ? '0 : drv_r + 1'b1;
        end else begin
          drv_c <= drv_c + 1'b1;
        end
      end
      if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                 wait_cnt <= '0;
      // The result strobe lands in DONE, one cycle after the decision.
      if (got_result) begin
        res_valid <= 1'b1;
        res_bits  <= signal_in;
      end else if (expired) begin
        res_valid   <= 1'b1;
        res_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_soml_frame_feeder.sv
// Scoreboard bench for soml_frame_feeder: a cycle-stepped driver plays frames and a
// decoder model, pushing expectations; a negedge monitor pops and compares.
module tb_soml_frame_feeder;

  localparam int N     = 32;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int Y_LEN = 8;
  localparam int RES_W = 12;
  localparam int TO    = 32;
  localparam int H_LEN = ROWS * COLS;
  localparam int TOT   = H_LEN + Y_LEN;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_valid;
  logic             ld_ready;
  logic [N-1:0]     ld_r;
  logic [N-1:0]     ld_i;
  logic             start;
  logic             H_in_valid;
  logic [N-1:0]     H_in_r;
  logic [N-1:0]     H_in_i;
  logic             Y_in_valid;
  logic [N-1:0]     Y_in_r;
  logic [N-1:0]     Y_in_i;
  logic             output_valid;
  logic [RES_W-1:0] signal_in;
  logic             res_valid;
  logic [RES_W-1:0] res_bits;
  logic             res_timeout;
  logic             busy;

  soml_frame_feeder #(
    .N(N), .ROWS(ROWS), .COLS(COLS), .Y_LEN(Y_LEN), .RES_W(RES_W), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_r(ld_r), .ld_i(ld_i), .start(start),
    .H_in_valid(H_in_valid), .H_in_r(H_in_r), .H_in_i(H_in_i),
    .Y_in_valid(Y_in_valid), .Y_in_r(Y_in_r), .Y_in_i(Y_in_i),
    .output_valid(output_valid), .signal_in(signal_in),
    .res_valid(res_valid), .res_bits(res_bits), .res_timeout(res_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] re;
    logic [N-1:0] im;
  } samp_t;

  typedef struct {
    int               cyc;
    logic [RES_W-1:0] bits;
    logic             tmo;
  } res_t;

  samp_t exp_h[$];
  samp_t exp_y[$];
  int    exp_start[$];
  res_t  exp_res[$];

  int total = 0;
  int bad   = 0;
  bit exp_busy = 1'b0;
  bit mon_on   = 1'b0;
  bit ov_noise = 1'b0;

  logic [N-1:0] words_r [TOT];
  logic [N-1:0] words_i [TOT];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic decoder_noise();
    output_valid = ov_noise ? 1'($urandom_range(1)) : 1'b0;
    signal_in    = RES_W'($urandom);
  endtask

  // One frame: load, replay, decoder reply at WAIT cycle w0 (w0 >= TO means never).
  task automatic apply_stimulus(input logic [RES_W-1:0] tx, input int w0, input bit gaps,
                                input bit hold_ld, input int stale_j, input int rst_j);
    int           k;
    int           s;
    int           jmax;
    samp_t        e;
    res_t         rr;
    logic [N-1:0] hm_r [ROWS][COLS];
    logic [N-1:0] hm_i [ROWS][COLS];
    k = 0;
    while (k < TOT) begin
      exp_busy = 1'b0;
      decoder_noise();
      if (gaps && $urandom_range(3) == 0) begin
        ld_valid = 1'b0;
        ld_r     = $urandom;
        ld_i     = $urandom;
      end else begin
        ld_valid = 1'b1;
        ld_r     = words_r[k];
        ld_i     = words_i[k];
        k++;
      end
      step();
    end
    s    = cyc;
    jmax = (rst_j < 0) ? H_LEN - 1 : rst_j;
    exp_start.push_back(s);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) begin
        hm_r[r][c] = words_r[c * ROWS + r];
        hm_i[r][c] = words_i[c * ROWS + r];
      end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (r * COLS + c <= jmax) begin
          e.cyc = s + 2 + r * COLS + c;
          e.re  = hm_r[r][c];
          e.im  = hm_i[r][c];
          exp_h.push_back(e);
        end
    for (int y = 0; y < Y_LEN; y++)
      if (y <= jmax) begin
        e.cyc = s + 2 + y;
        e.re  = words_r[H_LEN + y];
        e.im  = words_i[H_LEN + y];
        exp_y.push_back(e);
      end
    if (rst_j < 0) begin
      if (w0 < TO) begin
        rr.cyc  = s + 2 + H_LEN + w0 + 1;
        rr.bits = tx;
        rr.tmo  = 1'b0;
      end else begin
        rr.cyc  = s + 2 + H_LEN + TO;
        rr.bits = '0;
        rr.tmo  = 1'b1;
      end
      exp_res.push_back(rr);
    end
    for (int t = 0; t < 2 + H_LEN; t++) begin
      exp_busy = 1'b1;
      decoder_noise();
      if (stale_j >= 0 && t == 2 + stale_j) begin
        output_valid = 1'b1;
        signal_in    = 12'h7FF;
      end
      ld_valid = hold_ld;
      ld_r     = $urandom;
      ld_i     = $urandom;
      if (rst_j >= 0 && t == 2 + rst_j) rst = 1'b1;
      step();
      if (rst) begin
        rst      = 1'b0;
        ld_valid = 1'b0;
        return;
      end
    end
    for (int w = 0; w < TO; w++) begin
      exp_busy     = 1'b1;
      ld_valid     = hold_ld;
      ld_r         = $urandom;
      ld_i         = $urandom;
      output_valid = (w == w0);
      signal_in    = (w == w0) ? tx : RES_W'($urandom);
      step();
      if (w == w0) break;
    end
    exp_busy = 1'b1;
    decoder_noise();
    ld_valid = hold_ld;
    step();
  endtask

  task automatic random_words();
    for (int k = 0; k < TOT; k++) begin
      words_r[k] = $urandom;
      words_i[k] = $urandom;
    end
  endtask

  samp_t mh;
  samp_t my;
  res_t  mr;

  always @(negedge clk) begin
    if (mon_on) begin
      if (start) begin
        if (exp_start.size() == 0) check_output("start_unexpected", 64'(start), 64'd0);
        else check_output("start_cycle", 64'(cyc), 64'(exp_start.pop_front()));
      end
      if (H_in_valid) begin
        if (exp_h.size() == 0) check_output("h_unexpected", 64'(H_in_valid), 64'd0);
        else begin
          mh = exp_h.pop_front();
          check_output("h_cycle", 64'(cyc), 64'(mh.cyc));
          check_output("h_data", {H_in_r, H_in_i}, {mh.re, mh.im});
        end
      end else begin
        check_output("h_idle_zero", {H_in_r, H_in_i}, 64'd0);
      end
      if (Y_in_valid) begin
        if (exp_y.size() == 0) check_output("y_unexpected", 64'(Y_in_valid), 64'd0);
        else begin
          my = exp_y.pop_front();
          check_output("y_cycle", 64'(cyc), 64'(my.cyc));
          check_output("y_data", {Y_in_r, Y_in_i}, {my.re, my.im});
        end
      end else begin
        check_output("y_idle_zero", {Y_in_r, Y_in_i}, 64'd0);
      end
      if (res_valid) begin
        if (exp_res.size() == 0) check_output("res_unexpected", 64'(res_valid), 64'd0);
        else begin
          mr = exp_res.pop_front();
          check_output("res_cycle", 64'(cyc), 64'(mr.cyc));
          check_output("res_word", 64'({res_timeout, res_bits}), 64'({mr.tmo, mr.bits}));
        end
      end
      check_output("busy", 64'(busy), 64'(exp_busy));
      check_output("ld_ready", 64'(ld_ready), 64'(!exp_busy));
    end
  end

  initial begin
    rst          = 1'b1;
    ld_valid     = 1'b0;
    ld_r         = '0;
    ld_i         = '0;
    output_valid = 1'b0;
    signal_in    = '0;
    repeat (3) step();
    rst    = 1'b0;
    mon_on = 1'b1;

    for (int k = 0; k < H_LEN; k++) begin
      words_r[k] = N'(k + 1);
      words_i[k] = N'(-(k + 1));
    end
    for (int y = 0; y < Y_LEN; y++) begin
      words_r[H_LEN + y] = N'(101 + y);
      words_i[H_LEN + y] = N'(-(101 + y));
    end
    apply_stimulus(12'hA5C, 19, 1'b0, 1'b0, -1, -1);

    random_words();
    apply_stimulus(RES_W'($urandom), TO, 1'b0, 1'b0, -1, -1);

    random_words();
    apply_stimulus(12'h001, 5, 1'b0, 1'b1, 3, -1);

    random_words();
    apply_stimulus(RES_W'($urandom), 0, 1'b0, 1'b0, -1, 5);

    random_words();
    apply_stimulus(RES_W'($urandom), 10, 1'b1, 1'b0, -1, -1);

    random_words();
    apply_stimulus(RES_W'($urandom), TO - 1, 1'b0, 1'b0, -1, -1);

    ov_noise = 1'b1;
    for (int f = 0; f < 50; f++) begin
      random_words();
      apply_stimulus(RES_W'($urandom), int'($urandom_range(TO - 1)), 1'b1, 1'($urandom_range(1)), -1, -1);
    end

    ov_noise     = 1'b0;
    exp_busy     = 1'b0;
    ld_valid     = 1'b0;
    output_valid = 1'b0;
    repeat (5) step();
    mon_on = 1'b0;
    check_output("start_drained", 64'(exp_start.size()), 64'd0);
    check_output("h_drained", 64'(exp_h.size()), 64'd0);
    check_output("y_drained", 64'(exp_y.size()), 64'd0);
    check_output("res_drained", 64'(exp_res.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
